// File: rtl/layer_exec_ctrl.sv
// Layer execution controller: turns each sequencer layer command into a stream of
// tile commands for the compute engine, with weight-RAM reloads between kernel groups.
module layer_exec_ctrl #(
  parameter int LAYER_NUM_WIDTH  = 4,
  parameter int FM_SIZE_WIDTH    = 8,
  parameter int KERNEL_NUM_WIDTH = 8,
  parameter int PARA_X           = 3,
  parameter int PARA_Y           = 3,
  parameter int PARA_KERNEL      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_en,
  input  logic [LAYER_NUM_WIDTH-1:0]  layer_num,
  input  logic [3:0]                  layer_type,
  input  logic [FM_SIZE_WIDTH-1:0]    fm_size_out,
  input  logic [KERNEL_NUM_WIDTH-1:0] fm_depth,
  input  logic [KERNEL_NUM_WIDTH-1:0] kernel_num,
  input  logic                        init_fm_ram_ready,
  input  logic                        init_weight_ram_ready,
  output logic                        tile_valid,
  input  logic                        tile_ready,
  output logic [FM_SIZE_WIDTH-1:0]    tile_row,
  output logic [FM_SIZE_WIDTH-1:0]    tile_col,
  output logic [KERNEL_NUM_WIDTH-1:0] tile_kgroup,
  output logic                        tile_last,
  input  logic                        engine_busy,
  output logic                        wgt_req,
  input  logic                        wgt_ack,
  output logic                        layer_ready,
  output logic                        all_done
);

  localparam int FW = FM_SIZE_WIDTH + 1;
  localparam int CW = KERNEL_NUM_WIDTH + 2;

  localparam logic [3:0] TYPE_INIT = 4'd0;
  localparam logic [3:0] TYPE_CONV = 4'd1;
  localparam logic [3:0] TYPE_POOL = 4'd2;
  localparam logic [3:0] TYPE_FC   = 4'd3;
  localparam logic [3:0] TYPE_DONE = 4'd9;

  localparam logic [CW-1:0] GRP_CONV = CW'(PARA_KERNEL);
  localparam logic [CW-1:0] GRP_FC   = CW'(PARA_Y * PARA_KERNEL);
  localparam logic [FW-1:0] STEP_X   = FW'(PARA_X);
  localparam logic [FW-1:0] STEP_Y   = FW'(PARA_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_INIT_WAIT,
    S_ISSUE,
    S_WGT_REQ,
    S_DRAIN,
    S_READY,
    S_DONE
  } state_t;

  state_t                      state;
  logic                        seen;
  logic [LAYER_NUM_WIDTH-1:0]  last_num;
  logic [3:0]                  cur_type;
  logic [FM_SIZE_WIDTH-1:0]    cur_fm;
  logic [CW-1:0]               grp_size;
  logic [CW-1:0]               grp_src;
  logic [CW-1:0]               kbase;

  logic                        new_cmd;
  logic                        is_fc;
  logic                        col_end;
  logic                        row_end;
  logic                        grp_end;
  logic                        first_end;
  logic                        next_end;
  logic                        grp_final;
  logic                        next_grp_final;
  logic [CW-1:0]               kbase_nx;
  logic [FM_SIZE_WIDTH-1:0]    next_row;
  logic [FM_SIZE_WIDTH-1:0]    next_col;

  assign new_cmd = cmd_en && (!seen || (layer_num != last_num));

  // Group bookkeeping tracks the kernels consumed so far (kbase) instead of a
  // group count, so the final-group test is a compare rather than a division.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_row = tile_row;
    next_col = '0;
    is_fc    = (cur_type == TYPE_FC);
    col_end  = ({1'b0, tile_col} + STEP_X) >= {1'b0, cur_fm};
    row_end  = ({1'b0, tile_row} + STEP_Y) >= {1'b0, cur_fm};
    grp_end  = is_fc || (col_end && row_end);
    kbase_nx = kbase + grp_size;
    grp_final      = kbase_nx >= grp_src;
    next_grp_final = (kbase_nx + grp_size) >= grp_src;
    first_end = is_fc || ((STEP_X >= {1'b0, cur_fm}) && (STEP_Y >= {1'b0, cur_fm}));
    if (col_end) begin
      next_row = tile_row + FM_SIZE_WIDTH'(PARA_Y);
    end else begin
      next_col = tile_col + FM_SIZE_WIDTH'(PARA_X);
    end
    next_end = is_fc ||
               ((({1'b0, next_col} + STEP_X) >= {1'b0, cur_fm}) &&
                (({1'b0, next_row} + STEP_Y) >= {1'b0, cur_fm}));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
      state       <= S_IDLE;
      seen        <= 1'b0;
      last_num    <= '0;
      cur_type    <= '0;
      cur_fm      <= '0;
      grp_size    <= '0;
      grp_src     <= '0;
      kbase       <= '0;
      tile_valid  <= 1'b0;
      tile_row    <= '0;
      tile_col    <= '0;
      tile_kgroup <= '0;
      tile_last   <= 1'b0;
      wgt_req     <= 1'b0;
      layer_ready <= 1'b0;
      all_done    <= 1'b0;
    end else if (new_cmd && (state != S_DONE)) begin
      // Any new command (also mid-layer) restarts from LATCH.
      state       <= S_LATCH;
      seen        <= 1'b1;
      last_num    <= layer_num;
      cur_type    <= layer_type;
      cur_fm      <= fm_size_out;
      grp_size    <= (layer_type == TYPE_FC) ? GRP_FC : GRP_CONV;
      grp_src     <= CW'((layer_type == TYPE_POOL) ? fm_depth : kernel_num);
      tile_valid  <= 1'b0;
      tile_last   <= 1'b0;
      wgt_req     <= 1'b0;
      layer_ready <= 1'b0;
    end else begin
      case (state)
        S_LATCH: begin
          case (cur_type)
            TYPE_INIT: state <= S_INIT_WAIT;
            TYPE_CONV, TYPE_POOL, TYPE_FC: begin
              tile_row    <= '0;
              tile_col    <= '0;
              tile_kgroup <= '0;
              kbase       <= '0;
              tile_valid  <= 1'b1;
              tile_last   <= first_end && (grp_size >= grp_src);
              state       <= S_ISSUE;
            end
            TYPE_DONE: begin
              all_done <= 1'b1;
              state    <= S_DONE;
            end
            // Unknown types finish via READY, whose own cycle keeps layer_ready low for two cycles.
            default: state <= S_READY;
          endcase
        end
        S_INIT_WAIT: begin
          if (init_fm_ram_ready && init_weight_ram_ready) begin
            layer_ready <= 1'b1;
            state       <= S_READY;
          end
        end
        S_ISSUE: begin
          if (tile_ready) begin
            if (grp_end) begin
              tile_valid <= 1'b0;
              tile_last  <= 1'b0;
              if (grp_final) begin
                state <= S_DRAIN;
              end else begin
                wgt_req <= 1'b1;
                state   <= S_WGT_REQ;
              end
            end else begin
              tile_row  <= next_row;
              tile_col  <= next_col;
              tile_last <= next_end && grp_final;
            end
          end
        end
        S_WGT_REQ: begin
          if (wgt_ack) begin
            wgt_req     <= 1'b0;
            tile_kgroup <= tile_kgroup + KERNEL_NUM_WIDTH'(1);
            kbase       <= kbase_nx;
            tile_row    <= '0;
            tile_col    <= '0;
            tile_valid  <= 1'b1;
            tile_last   <= first_end && next_grp_final;
            state       <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (!engine_busy) begin
            layer_ready <= 1'b1;
            state       <= S_READY;
          end
        end
        S_READY: layer_ready <= 1'b1;
        S_IDLE, S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_exec_ctrl.sv
// Self-checking bench for layer_exec_ctrl: directed layers plus randomized configs and
// backpressure, checked against a loop-based tile-list model.
module tb_layer_exec_ctrl;

  localparam int PX = 3;
  localparam int PY = 3;
  localparam int PK = 2;
  localparam int LIMIT = 3000;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] kg;
    logic       last;
  } tile_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_en = 1'b0;
  logic [3:0] layer_num = '0;
  logic [3:0] layer_type = '0;
  logic [7:0] fm_size_out = '0;
  logic [7:0] fm_depth = '0;
  logic [7:0] kernel_num = '0;
  logic       init_fm_ram_ready = 1'b0;
  logic       init_weight_ram_ready = 1'b0;
  logic       tile_valid;
  logic       tile_ready = 1'b0;
  logic [7:0] tile_row;
  logic [7:0] tile_col;
  logic [7:0] tile_kgroup;
  logic       tile_last;
  logic       engine_busy = 1'b0;
  logic       wgt_req;
  logic       wgt_ack = 1'b0;
  logic       layer_ready;
  logic       all_done;

  int    checks = 0;
  int    failures = 0;
  tile_t exp_q[$];
  int    exp_wgt = 0;

  layer_exec_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .cmd_en                (cmd_en),
    .layer_num             (layer_num),
    .layer_type            (layer_type),
    .fm_size_out           (fm_size_out),
    .fm_depth              (fm_depth),
    .kernel_num            (kernel_num),
    .init_fm_ram_ready     (init_fm_ram_ready),
    .init_weight_ram_ready (init_weight_ram_ready),
    .tile_valid            (tile_valid),
    .tile_ready            (tile_ready),
    .tile_row              (tile_row),
    .tile_col              (tile_col),
    .tile_kgroup           (tile_kgroup),
    .tile_last             (tile_last),
    .engine_busy           (engine_busy),
    .wgt_req               (wgt_req),
    .wgt_ack               (wgt_ack),
    .layer_ready           (layer_ready),
    .all_done              (all_done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: groups = ceil(source/group size) (min 1), tiles = ceil(fm/PARA) per axis (min 1).
  function automatic void build_model(input int typ, input int fm, input int depth, input int kn);
    int gsize, src, ngrp, nr, nc;
    tile_t t;
    exp_q.delete();
    gsize = (typ == 3) ? PY * PK : PK;
    src   = (typ == 2) ? depth : kn;
    ngrp  = (src + gsize - 1) / gsize;
    if (ngrp < 1) ngrp = 1;
    nr = (typ == 3) ? 1 : (fm + PY - 1) / PY;
    nc = (typ == 3) ? 1 : (fm + PX - 1) / PX;
    if (nr < 1) nr = 1;
    if (nc < 1) nc = 1;
    for (int g = 0; g < ngrp; g++)
      for (int r = 0; r < nr; r++)
        for (int c = 0; c < nc; c++) begin
          t.row  = 8'(r * PY);
          t.col  = 8'(c * PX);
          t.kg   = 8'(g);
          t.last = (g == ngrp - 1) && (r == nr - 1) && (c == nc - 1);
          exp_q.push_back(t);
        end
    exp_wgt = ngrp - 1;
  endfunction

  // Presents a new command; returns at the negedge after the detecting edge (plus one for tile layers).
  task automatic start_cmd(input int num, input int typ, input int fm, input int depth, input int kn);
    @(negedge clk);
    tile_ready  = 1'b0;
    wgt_ack     = 1'b0;
    layer_num   = 4'(num);
    layer_type  = 4'(typ);
    fm_size_out = 8'(fm);
    fm_depth    = 8'(depth);
    kernel_num  = 8'(kn);
    cmd_en      = 1'b1;
    build_model(typ, fm, depth, kn);
    @(negedge clk);
    check("cmd_ready_low", 32'(layer_ready), 32'd0);
    check("cmd_valid_low", 32'(tile_valid), 32'd0);
    if (typ >= 1 && typ <= 3) begin
      @(negedge clk);
      check("first_valid", 32'(tile_valid), 32'd1);
    end
  endtask

  // Drains one layer's tiles and weight handshakes, then checks counts and ready latency.
  task automatic collect(input bit rnd, input int busy);
    int    idx = 0;
    int    wgt_cnt = 0;
    int    cyc = 0;
    int    busy_left = busy;
    int    last_cyc = -1;
    int    drop_cyc = -1;
    bit    all_in = 1'b0;
    bit    stalled = 1'b0;
    bit    ack_prev = 1'b0;
    tile_t cur, prev;
    prev = '0;
    engine_busy = (busy > 0);
    while (cyc < LIMIT) begin
      if (layer_ready) break;
      cur.row  = tile_row;
      cur.col  = tile_col;
      cur.kg   = tile_kgroup;
      cur.last = tile_last;
      if (stalled) begin
        check("stall_valid", 32'(tile_valid), 32'd1);
        check("stall_fields", 32'(cur), 32'(prev));
      end
      if (all_in && busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          engine_busy = 1'b0;
          drop_cyc = cyc;
        end
      end
      if (ack_prev) check("wgt_req_fall", 32'(wgt_req), 32'd0);
      if (wgt_req && !ack_prev && (!rnd || $urandom_range(0, 2) == 0)) begin
        wgt_ack  = 1'b1;
        ack_prev = 1'b1;
        wgt_cnt++;
      end else begin
        wgt_ack  = 1'b0;
        ack_prev = 1'b0;
      end
      tile_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (tile_valid && tile_ready) begin
        if (idx < exp_q.size()) check($sformatf("tile%0d", idx), 32'(cur), 32'(exp_q[idx]));
        else check("tile_overrun", idx, exp_q.size());
        idx++;
        if (idx == exp_q.size()) begin
          all_in = 1'b1;
          last_cyc = cyc;
        end
      end
      stalled = tile_valid && !tile_ready;
      prev = cur;
      @(negedge clk);
      cyc++;
    end
    tile_ready  = 1'b0;
    wgt_ack     = 1'b0;
    engine_busy = 1'b0;
    check("layer_done_in_time", 32'(layer_ready), 32'd1);
    check("tile_count", idx, exp_q.size());
    check("wgt_handshakes", wgt_cnt, exp_wgt);
    check("ready_latency", cyc, (busy > 0) ? drop_cyc + 1 : last_cyc + 2);
  endtask

  initial begin
    #2;
    check("reset_flags", 32'({tile_valid, tile_last, wgt_req, layer_ready, all_done}), 32'd0);
    check("reset_fields", 32'({tile_row, tile_col, tile_kgroup}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Init layer: RAM readies rise 5 and 9 cycles after the command is seen.
    start_cmd(0, 0, 0, 0, 0);
    for (int c = 1; c <= 9; c++) begin
      check("init_wait_ready", 32'(layer_ready), 32'd0);
      check("init_no_tile", 32'(tile_valid), 32'd0);
      if (c == 5) init_fm_ram_ready = 1'b1;
      if (c == 9) init_weight_ram_ready = 1'b1;
      @(negedge clk);
    end
    check("init_ready", 32'(layer_ready), 32'd1);

    start_cmd(1, 1, 8, 0, 6);
    collect(1'b0, 0);
    start_cmd(2, 2, 4, 2, 0);
    collect(1'b0, 0);
    start_cmd(3, 3, 0, 0, 12);
    collect(1'b0, 20);
    start_cmd(4, 1, 8, 0, 6);
    collect(1'b1, 0);

    for (int i = 0; i < 6; i++) begin
      start_cmd(5 + i, int'($urandom_range(1, 3)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 13)));
      collect(1'b1, int'($urandom_range(0, 3)));
    end

    // Unrecognised layer type completes with no tiles.
    start_cmd(11, 5, 0, 0, 0);
    @(negedge clk);
    check("other_ready_gap", 32'(layer_ready), 32'd0);
    @(negedge clk);
    check("other_ready", 32'(layer_ready), 32'd1);

    // Abort mid-conv by changing layer_num; the layer restarts from (0,0).
    start_cmd(12, 1, 8, 0, 6);
    tile_ready = 1'b1;
    repeat (4) @(negedge clk);
    start_cmd(13, 1, 8, 0, 6);
    collect(1'b0, 0);

    // Async reset mid-issue, then the same layer_num must be accepted as new.
    start_cmd(14, 1, 8, 0, 6);
    tile_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    cmd_en = 1'b0;
    tile_ready = 1'b0;
    #1;
    check("rst_valid", 32'(tile_valid), 32'd0);
    check("rst_ready", 32'(layer_ready), 32'd0);
    check("rst_fields", 32'({tile_row, tile_col, tile_kgroup}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    start_cmd(14, 1, 8, 0, 6);
    collect(1'b1, 2);

    // Done command: all_done is sticky and later commands are ignored.
    start_cmd(15, 9, 0, 0, 0);
    @(negedge clk);
    check("all_done_set", 32'(all_done), 32'd1);
    check("done_ready_low", 32'(layer_ready), 32'd0);
    layer_num  = 4'd3;
    layer_type = 4'd1;
    repeat (4) begin
      @(negedge clk);
      check("done_no_tile", 32'(tile_valid), 32'd0);
    end
    check("all_done_sticky", 32'(all_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
